// File: rtl/arb_mux.sv
// N-channel arbitrating mux into a single registered output slot (fixed-select or round-robin).
// Optional macro ARB_MUX_CNT_EN adds a 16-bit output-transfer counter port xfer_count.
module arb_mux #(
  parameter int BUS_BITS = 64,
  parameter int NUM_IN   = 4,
  parameter int MODE     = 1,
  localparam int SEL_BITS = $clog2(NUM_IN)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IN*BUS_BITS-1:0] in_data,
  input  logic [NUM_IN-1:0]          in_valid,
  output logic [NUM_IN-1:0]          in_ready,
  input  logic [SEL_BITS-1:0]        sel,
  output logic [BUS_BITS-1:0]        out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SEL_BITS-1:0]        out_sel
`ifdef ARB_MUX_CNT_EN
  ,
  output logic [15:0]                xfer_count
`endif
);

  logic [BUS_BITS-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [SEL_BITS-1:0] out_sel_q, out_sel_d;
  logic [SEL_BITS-1:0] ptr_q, ptr_d;

  logic [NUM_IN-1:0]   grant;
  logic [SEL_BITS-1:0] grant_idx;
  logic [BUS_BITS-1:0] grant_data;
  logic [SEL_BITS:0]   cand;
  logic                found;
  logic                load_en;
  logic                in_xfer;
  logic                out_xfer;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    if (MODE == 0) begin
      // a select value with no matching channel simply grants nothing
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel == SEL_BITS'(i)) begin
          grant[i]  = 1'b1;
          grant_idx = SEL_BITS'(i);
        end
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        cand = {1'b0, ptr_q} + (SEL_BITS+1)'(k);
        if (cand >= (SEL_BITS+1)'(NUM_IN)) begin
          cand = cand - (SEL_BITS+1)'(NUM_IN);
        end
        if (!found && in_valid[cand[SEL_BITS-1:0]]) begin
          found                      = 1'b1;
          grant[cand[SEL_BITS-1:0]]  = 1'b1;
          grant_idx                  = cand[SEL_BITS-1:0];
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) begin
        grant_data = in_data[i*BUS_BITS +: BUS_BITS];
      end
    end
  end

  assign load_en  = !out_valid_q || out_ready;
  assign in_ready = load_en ? grant : '0;
  assign in_xfer  = |(in_valid & in_ready);
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (in_xfer) begin
      out_data_d  = grant_data;
      out_valid_d = 1'b1;
      out_sel_d   = grant_idx;
      ptr_d       = (grant_idx == SEL_BITS'(NUM_IN-1)) ? '0 : grant_idx + SEL_BITS'(1);
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

`ifdef ARB_MUX_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // wraps naturally at 16 bits
  assign cnt_d = out_xfer ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_count = cnt_q;
`else
  // transfer counter not built
`endif

endmodule
